// File: rtl/rand_gen.sv
// rand_gen: 8-bit maximal-length Fibonacci LFSR (x^8+x^6+x^5+x^4+1).
// The register steps once per clock and can be reseeded at run time.
// A requested all-zero seed is replaced with ZERO_SUB, so the state
// can never lock up at zero.
module rand_gen #(
   parameter logic [7:0] RESET_SEED = 8'h01,
   parameter logic [7:0] ZERO_SUB   = 8'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] seed_i,
   input  logic       set_seed_i,
   output logic [7:0] rand_o
);

   // An all-zero state is a fixed point of the LFSR, so neither constant may be zero.
   if (RESET_SEED == 8'h00) begin : g_bad_reset_seed
      $error("rand_gen: RESET_SEED must be nonzero");
   end
   if (ZERO_SUB == 8'h00) begin : g_bad_zero_sub
      $error("rand_gen: ZERO_SUB must be nonzero");
   end

   logic [7:0] s;
   logic [7:0] s_adv;
   logic [7:0] seed_safe;
   logic       fb;

   // Feedback taps, the shifted state, and the seed with zero replaced.
   always_comb begin
      fb        = s[7] ^ s[5] ^ s[4] ^ s[3];
      s_adv     = {s[6:0], fb};
      seed_safe = (seed_i == 8'h00) ? ZERO_SUB : seed_i;
   end

   // State register. Reset has priority over a seed load, and a seed load over advancing.
   always_ff @(posedge clk) begin
      if (!rst)
         s <= RESET_SEED;
      else if (set_seed_i)
         s <= seed_safe;
      else
         s <= s_adv;
   end

   assign rand_o = s;

endmodule

// File: tb/tb_rand_gen.sv
// tb_rand_gen: table-driven directed vectors, then a long free-run check
// of the no-zero, 255-distinct-values and period-255 properties.
module tb_rand_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] seed_i;
   logic       set_seed_i;
   logic [7:0] rand_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       rst;
      logic       set;
      logic [7:0] seed;
      logic [7:0] exp;
      string      name;
   } vec_t;

   localparam int NV = 27;
   vec_t vecs [NV];

   rand_gen dut (
      .clk        (clk),
      .rst        (rst),
      .seed_i     (seed_i),
      .set_seed_i (set_seed_i),
      .rand_o     (rand_o)
   );

   // 10 ns clock period.
   always #5 clk = ~clk;

   // Independent reference step, written from the feedback equation.
   function automatic logic [7:0] ref_next(input logic [7:0] v);
      logic b;
      b = v[7] ^ v[5] ^ v[4] ^ v[3];
      return {v[6:0], b};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic st, input logic [7:0] sd,
                               input logic [7:0] e, input string n);
      vec_t v;
      v.rst = r; v.set = st; v.seed = sd; v.exp = e; v.name = n;
      return v;
   endfunction

   logic [7:0] hist [0:511];
   logic [7:0] model;
   bit         seen [0:255];
   int         zero_hits, period_err, model_err, distinct;

   initial begin
      // Expected values are worked out by hand from fb = s7^s5^s4^s3.
      vecs[0]  = mk(1'b0, 1'b1, 8'h5A, 8'h01, "reset_ignores_seed");
      vecs[1]  = mk(1'b1, 1'b0, 8'h00, 8'h02, "seq_02");
      vecs[2]  = mk(1'b1, 1'b0, 8'h00, 8'h04, "seq_04");
      vecs[3]  = mk(1'b1, 1'b0, 8'h00, 8'h08, "seq_08");
      vecs[4]  = mk(1'b1, 1'b0, 8'h00, 8'h11, "seq_11");
      vecs[5]  = mk(1'b1, 1'b0, 8'h00, 8'h23, "seq_23");
      vecs[6]  = mk(1'b1, 1'b0, 8'h00, 8'h47, "seq_47");
      vecs[7]  = mk(1'b1, 1'b0, 8'h00, 8'h8E, "seq_8E");
      vecs[8]  = mk(1'b1, 1'b1, 8'hA3, 8'hA3, "seed_A3");
      vecs[9]  = mk(1'b1, 1'b0, 8'hFF, 8'h46, "adv_A3");
      vecs[10] = mk(1'b1, 1'b0, 8'h00, 8'h8C, "adv_46");
      vecs[11] = mk(1'b1, 1'b1, 8'h00, 8'h01, "zero_seed_sub");
      vecs[12] = mk(1'b1, 1'b0, 8'h00, 8'h02, "zero_then_02");
      vecs[13] = mk(1'b1, 1'b0, 8'h00, 8'h04, "zero_then_04");
      vecs[14] = mk(1'b1, 1'b1, 8'h3C, 8'h3C, "hold_3C_1");
      vecs[15] = mk(1'b1, 1'b1, 8'h3C, 8'h3C, "hold_3C_2");
      vecs[16] = mk(1'b1, 1'b1, 8'h3C, 8'h3C, "hold_3C_3");
      vecs[17] = mk(1'b1, 1'b1, 8'h3C, 8'h3C, "hold_3C_4");
      vecs[18] = mk(1'b1, 1'b0, 8'h00, 8'h79, "adv_3C");
      vecs[19] = mk(1'b1, 1'b0, 8'h00, 8'hF3, "adv_79");
      vecs[20] = mk(1'b0, 1'b1, 8'h5A, 8'h01, "midrun_reset_wins");
      vecs[21] = mk(1'b1, 1'b0, 8'h5A, 8'h02, "after_reset_02");
      vecs[22] = mk(1'b1, 1'b0, 8'hx,  8'h04, "x_seed_ignored");
      vecs[23] = mk(1'b1, 1'b1, 8'h80, 8'h80, "seed_80");
      vecs[24] = mk(1'b1, 1'b0, 8'h00, 8'h01, "adv_80");
      vecs[25] = mk(1'b0, 1'b0, 8'h00, 8'h01, "reset_plain");
      vecs[26] = mk(1'b0, 1'b0, 8'h00, 8'h01, "reset_held");

      rst = 1'b1; set_seed_i = 1'b0; seed_i = 8'h00;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         rst = vecs[i].rst; set_seed_i = vecs[i].set; seed_i = vecs[i].seed;
         @(posedge clk); #1;
         check(vecs[i].name, rand_o, vecs[i].exp);
      end

      // Long free-run from reset, checked against the reference step.
      rst = 1'b0; set_seed_i = 1'b0; seed_i = 8'h00;
      @(posedge clk); #1;
      check("freerun_reset", rand_o, 8'h01);
      rst = 1'b1;
      model = 8'h01;
      zero_hits = 0; period_err = 0; model_err = 0; distinct = 0;
      foreach (seen[k]) seen[k] = 1'b0;
      for (int n = 0; n < 65536; n++) begin
         if (n < 512) hist[n] = rand_o;
         if (rand_o === 8'h00) zero_hits++;
         if (rand_o !== model) model_err++;
         if (!seen[rand_o]) begin
            seen[rand_o] = 1'b1;
            distinct++;
         end
         model = ref_next(model);
         @(posedge clk); #1;
      end
      for (int n = 0; n < 257; n++)
         if (hist[n] !== hist[n+255]) period_err++;

      check_int("freerun_no_zero", zero_hits, 0);
      check_int("freerun_model", model_err, 0);
      check_int("freerun_distinct", distinct, 255);
      check_int("freerun_period", period_err, 0);
      check("freerun_period_inner", hist[100], hist[355]);

      // Reseeding after the long run still behaves the same way.
      set_seed_i = 1'b1; seed_i = 8'hA3;
      @(posedge clk); #1;
      check("late_seed_A3", rand_o, 8'hA3);
      set_seed_i = 1'b0;
      @(posedge clk); #1;
      check("late_adv_A3", rand_o, 8'h46);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
